// File: rtl/rng_health_pkg.sv
// Shared constants and helpers for the RNG health monitor.
// Holds the default parameter values, a constant-foldable clog2, the
// default window length and the default run-length type.
package rng_health_pkg;

  localparam int DEF_WIN_LOG2   = 7;
  localparam int DEF_ONES_LO    = 48;
  localparam int DEF_ONES_HI    = 80;
  localparam int DEF_LRUN_MAX   = 10;
  localparam int DEF_RCT_CUTOFF = 16;
  localparam int DEF_FAIL_LIMIT = 3;

  // Ceiling log2, usable in parameter expressions.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 << i) < value) begin
        result = i + 1;
      end else begin
        result = result;
      end
    end
    return result;
  endfunction

  localparam int WIN_LEN = 32'sd1 << DEF_WIN_LOG2;
  localparam int DEF_RW  = clog2(DEF_RCT_CUTOFF + 1);

  typedef logic [DEF_RW-1:0] run_len_t;

endpackage

// File: rtl/run_length_tracker.sv
// Continuous run-length tracker for the sampled bitstream.
// Ports:
//   clk, rstn, clear : clock, async active-low reset, sync clear
//   valid, bit_in    : sampled bit and its qualifier
//   restart          : this valid bit closes a window; the window maximum
//                      restarts from the run length that includes this bit
//   win_max          : window maximum including the current bit (combinational)
//   rct_hit          : the current bit brings the run to RCT_CUTOFF
module run_length_tracker
  import rng_health_pkg::*;
#(
  parameter int RCT_CUTOFF = DEF_RCT_CUTOFF,
  parameter int RW         = clog2(RCT_CUTOFF + 1)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          clear,
  input  logic          valid,
  input  logic          bit_in,
  input  logic          restart,
  output logic [RW-1:0] win_max,
  output logic          rct_hit
);

  localparam logic [RW-1:0] CUTOFF = RCT_CUTOFF[RW-1:0];

  logic          prev_bit;
  logic [RW-1:0] run_len;
  logic [RW-1:0] run_next;
  logic [RW-1:0] max_acc;

  // Next run length. After reset run_len is 0 and prev_bit 0, so the first
  // bit always yields 1 whichever value it has.
  always_comb begin
    run_next = {RW{1'b0}};
    if (bit_in == prev_bit) begin
      if (run_len == CUTOFF) begin
        run_next = CUTOFF;
      end else begin
        run_next = run_len + RW'(1'b1);
      end
    end else begin
      run_next = RW'(1'b1);
    end
  end

  // Window maximum including the bit presented this cycle.
  always_comb begin
    win_max = max_acc;
    if (run_next > max_acc) begin
      win_max = run_next;
    end else begin
      win_max = max_acc;
    end
  end

  assign rct_hit = valid && (run_next == CUTOFF);

  // Run state; a run spanning a window boundary seeds the next window's maximum.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      prev_bit <= 1'b0;
      run_len  <= {RW{1'b0}};
      max_acc  <= {RW{1'b0}};
    end else if (clear) begin
      prev_bit <= 1'b0;
      run_len  <= {RW{1'b0}};
      max_acc  <= {RW{1'b0}};
    end else if (valid) begin
      prev_bit <= bit_in;
      run_len  <= run_next;
      max_acc  <= restart ? run_next : win_max;
    end
  end

endmodule

// File: rtl/rng_health_monitor.sv
// Streaming online health monitor for the RNG bitstream: monobit band test,
// longest-run test and continuous repetition-count test over 2^WIN_LOG2-bit
// windows, with sticky error flags and a consecutive-failure alarm.
// Ports:
//   clk, rstn, clear    : clock, async active-low reset, sync clear (same effect)
//   bit_valid, bit_in   : sampled random bit
//   win_done            : one-cycle pulse after the last bit of a window
//   ones_count, max_run : statistics of the last completed window
//   err_freq/runs/rct   : sticky per-test failure flags
//   fail_cnt            : consecutive failing windows, saturating at FAIL_LIMIT
//   alarm               : sticky global alarm
module rng_health_monitor
  import rng_health_pkg::*;
#(
  parameter int WIN_LOG2   = DEF_WIN_LOG2,
  parameter int ONES_LO    = DEF_ONES_LO,
  parameter int ONES_HI    = DEF_ONES_HI,
  parameter int LRUN_MAX   = DEF_LRUN_MAX,
  parameter int RCT_CUTOFF = DEF_RCT_CUTOFF,
  parameter int FAIL_LIMIT = DEF_FAIL_LIMIT,
  localparam int RW        = clog2(RCT_CUTOFF + 1)
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                clear,
  input  logic                bit_valid,
  input  logic                bit_in,
  output logic                win_done,
  output logic [WIN_LOG2:0]   ones_count,
  output logic [RW-1:0]       max_run,
  output logic                err_freq,
  output logic                err_runs,
  output logic                err_rct,
  output logic [3:0]          fail_cnt,
  output logic                alarm
);

  localparam int                  WIN_LAST_I = (32'sd1 << WIN_LOG2) - 1;
  localparam logic [WIN_LOG2-1:0] WIN_LAST   = WIN_LAST_I[WIN_LOG2-1:0];
  localparam logic [WIN_LOG2:0]   LO         = ONES_LO[WIN_LOG2:0];
  localparam logic [WIN_LOG2:0]   HI         = ONES_HI[WIN_LOG2:0];
  localparam logic [RW-1:0]       LRUN       = LRUN_MAX[RW-1:0];
  localparam logic [3:0]          LIMIT      = FAIL_LIMIT[3:0];

  logic [WIN_LOG2-1:0] pos;
  logic [WIN_LOG2:0]   ones_acc;
  logic [WIN_LOG2:0]   ones_next;
  logic [RW-1:0]       win_max;
  logic                rct_hit;
  logic                win_end;
  logic                freq_fail;
  logic                runs_fail;
  logic [3:0]          fail_cnt_next;

  assign win_end   = bit_valid && (pos == WIN_LAST);
  assign ones_next = ones_acc + {{WIN_LOG2{1'b0}}, bit_in};

  run_length_tracker #(
    .RCT_CUTOFF (RCT_CUTOFF),
    .RW         (RW)
  ) u_run (
    .clk     (clk),
    .rstn    (rstn),
    .clear   (clear),
    .valid   (bit_valid),
    .bit_in  (bit_in),
    .restart (win_end),
    .win_max (win_max),
    .rct_hit (rct_hit)
  );

  // Window verdict and the fail count it would produce, including the current bit.
  always_comb begin
    freq_fail     = 1'b0;
    runs_fail     = 1'b0;
    fail_cnt_next = fail_cnt;
    if ((ones_next < LO) || (ones_next > HI)) begin
      freq_fail = 1'b1;
    end else begin
      freq_fail = 1'b0;
    end
    if (win_max > LRUN) begin
      runs_fail = 1'b1;
    end else begin
      runs_fail = 1'b0;
    end
    if (freq_fail || runs_fail) begin
      if (fail_cnt >= LIMIT) begin
        fail_cnt_next = LIMIT;
      end else begin
        fail_cnt_next = fail_cnt + 4'd1;
      end
    end else begin
      fail_cnt_next = 4'd0;
    end
  end

  // Window bookkeeping, registered statistics and sticky flags.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pos        <= {WIN_LOG2{1'b0}};
      ones_acc   <= {(WIN_LOG2+1){1'b0}};
      win_done   <= 1'b0;
      ones_count <= {(WIN_LOG2+1){1'b0}};
      max_run    <= {RW{1'b0}};
      err_freq   <= 1'b0;
      err_runs   <= 1'b0;
      err_rct    <= 1'b0;
      fail_cnt   <= 4'd0;
      alarm      <= 1'b0;
    end else if (clear) begin
      pos        <= {WIN_LOG2{1'b0}};
      ones_acc   <= {(WIN_LOG2+1){1'b0}};
      win_done   <= 1'b0;
      ones_count <= {(WIN_LOG2+1){1'b0}};
      max_run    <= {RW{1'b0}};
      err_freq   <= 1'b0;
      err_runs   <= 1'b0;
      err_rct    <= 1'b0;
      fail_cnt   <= 4'd0;
      alarm      <= 1'b0;
    end else begin
      win_done <= win_end;
      if (bit_valid) begin
        // pos is exactly WIN_LOG2 bits wide, so it wraps to 0 after the last bit.
        pos      <= pos + {{(WIN_LOG2-1){1'b0}}, 1'b1};
        ones_acc <= win_end ? {(WIN_LOG2+1){1'b0}} : ones_next;
      end
      if (win_end) begin
        ones_count <= ones_next;
        max_run    <= win_max;
        fail_cnt   <= fail_cnt_next;
        if (freq_fail) begin
          err_freq <= 1'b1;
        end
        if (runs_fail) begin
          err_runs <= 1'b1;
        end
        if ((freq_fail || runs_fail) && (fail_cnt_next == LIMIT)) begin
          alarm <= 1'b1;
        end
      end
      // RCT fires on the bit itself, independent of window position.
      if (rct_hit) begin
        err_rct <= 1'b1;
        alarm   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rng_health_monitor.sv
module tb_rng_health_monitor;

  localparam int WIN_LOG2 = 4;
  localparam int WIN_LEN  = 16;
  localparam int ONES_LO  = 4;
  localparam int ONES_HI  = 12;
  localparam int LRUN_MAX = 6;
  localparam int CUTOFF   = 8;
  localparam int LIMIT    = 2;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       clear = 1'b0;
  logic       bit_valid = 1'b0;
  logic       bit_in = 1'b0;
  logic       win_done;
  logic [4:0] ones_count;
  logic [3:0] max_run;
  logic       err_freq;
  logic       err_runs;
  logic       err_rct;
  logic [3:0] fail_cnt;
  logic       alarm;
  logic [17:0] act_vec;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rng_health_monitor #(
    .WIN_LOG2   (WIN_LOG2),
    .ONES_LO    (ONES_LO),
    .ONES_HI    (ONES_HI),
    .LRUN_MAX   (LRUN_MAX),
    .RCT_CUTOFF (CUTOFF),
    .FAIL_LIMIT (LIMIT)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .clear      (clear),
    .bit_valid  (bit_valid),
    .bit_in     (bit_in),
    .win_done   (win_done),
    .ones_count (ones_count),
    .max_run    (max_run),
    .err_freq   (err_freq),
    .err_runs   (err_runs),
    .err_rct    (err_rct),
    .fail_cnt   (fail_cnt),
    .alarm      (alarm)
  );

  assign act_vec = {win_done, ones_count, max_run, err_freq, err_runs, err_rct, fail_cnt, alarm};

  // ---------------- reference model (per-bit rules, window as a bit queue)
  bit m_have_prev;
  bit m_prev;
  int m_run;
  int m_win_max;
  int m_fails;
  bit win_q[$];
  bit e_done, e_freq, e_runs, e_rct, e_alarm;
  int e_ones, e_max;

  function automatic logic [17:0] exp_vec();
    logic [4:0] o;
    logic [3:0] mx;
    logic [3:0] fc;
    o  = e_ones[4:0];
    mx = e_max[3:0];
    fc = m_fails[3:0];
    return {e_done, o, mx, e_freq, e_runs, e_rct, fc, e_alarm};
  endfunction

  task automatic model_reset();
    m_have_prev = 1'b0; m_prev = 1'b0; m_run = 0; m_win_max = 0; m_fails = 0;
    win_q.delete();
    e_done = 1'b0; e_freq = 1'b0; e_runs = 1'b0; e_rct = 1'b0; e_alarm = 1'b0;
    e_ones = 0; e_max = 0;
  endtask

  task automatic model_accept(input bit b);
    int n;
    bit ff, rf;
    if (!m_have_prev || b != m_prev) m_run = 1;
    else if (m_run < CUTOFF) m_run = m_run + 1;
    m_have_prev = 1'b1;
    m_prev = b;
    win_q.push_back(b);
    if (m_run > m_win_max) m_win_max = m_run;
    if (m_run == CUTOFF) begin e_rct = 1'b1; e_alarm = 1'b1; end
    if (win_q.size() == WIN_LEN) begin
      n = 0;
      foreach (win_q[i]) n += int'(win_q[i]);
      e_ones = n;
      e_max = m_win_max;
      e_done = 1'b1;
      ff = (n < ONES_LO) || (n > ONES_HI);
      rf = (m_win_max > LRUN_MAX);
      if (ff) e_freq = 1'b1;
      if (rf) e_runs = 1'b1;
      if (ff || rf) begin
        if (m_fails < LIMIT) m_fails = m_fails + 1;
        if (m_fails == LIMIT) e_alarm = 1'b1;
      end else begin
        m_fails = 0;
      end
      win_q.delete();
      m_win_max = m_run;  // a run crossing the boundary counts in the new window
    end
  endtask

  // One clock: drive at negedge, sample 1 time unit after the posedge.
  task automatic step(input bit v, input bit b, input bit c);
    @(negedge clk);
    bit_valid = v; bit_in = b; clear = c;
    @(posedge clk);
    #1;
    bit_valid = 1'b0; clear = 1'b0;
    e_done = 1'b0;
    if (c) model_reset();
    else if (v) model_accept(b);
  endtask

  // ---------------- tests
  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bit_valid = ~bit_valid;
      bit_in = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      checks++;
      if (act_vec !== 18'd0) begin
        failures++;
        $display("FAIL reset_hold cyc=%0d got=%h want=%h", i, act_vec, 18'd0);
      end
    end
    @(negedge clk);
    rstn = 1'b1; bit_valid = 1'b0;
    model_reset();
  endtask

  task automatic test_alternating();
    for (int i = 0; i < WIN_LEN; i++) begin
      step(1'b1, (i % 2) == 0, 1'b0);
      checks++;
      if (act_vec !== exp_vec()) begin
        failures++;
        $display("FAIL alt_step%0d got=%h want=%h", i, act_vec, exp_vec());
      end
    end
    checks++;
    if (win_done !== 1'b1 || ones_count !== 5'd8 || max_run !== 4'd1 || err_freq !== 1'b0 ||
        err_runs !== 1'b0 || err_rct !== 1'b0 || fail_cnt !== 4'd0 || alarm !== 1'b0) begin
      failures++;
      $display("FAIL alt_window got=%h want done=1 ones=8 max=1 rest=0", act_vec);
    end
    step(1'b0, 1'b0, 1'b0);
    checks++;
    if (win_done !== 1'b0 || ones_count !== 5'd8) begin
      failures++;
      $display("FAIL alt_pulse_hold done=%b ones=%0d want done=0 ones=8", win_done, ones_count);
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 5; i++) step(1'b1, 1'($urandom_range(0, 1)), 1'b0);
    @(posedge clk);
    #3;
    rstn = 1'b0;
    #1;
    checks++;
    if (act_vec !== 18'd0) begin
      failures++;
      $display("FAIL async_reset got=%h want=%h", act_vec, 18'd0);
    end
    model_reset();
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < WIN_LEN; i++) begin
      step(1'b1, 1'($urandom_range(0, 1)), 1'b0);
      checks++;
      if (act_vec !== exp_vec()) begin
        failures++;
        $display("FAIL async_win_step%0d got=%h want=%h", i, act_vec, exp_vec());
      end
    end
    checks++;
    if (win_done !== 1'b1) begin
      failures++;
      $display("FAIL async_win_from_bit0 win_done=%b want 1", win_done);
    end
  endtask

  task automatic test_freq_fail();
    logic [15:0] pat;
    step(1'b0, 1'b0, 1'b1);
    pat = 16'b1111_1101_1111_1011;
    for (int i = 15; i >= 0; i--) begin
      step(1'b1, pat[i], 1'b0);
      checks++;
      if (act_vec !== exp_vec()) begin
        failures++;
        $display("FAIL freq_step%0d got=%h want=%h", i, act_vec, exp_vec());
      end
    end
    checks++;
    if (ones_count !== 5'd14 || max_run !== 4'd6 || err_freq !== 1'b1 || err_runs !== 1'b0 ||
        fail_cnt !== 4'd1 || alarm !== 1'b0) begin
      failures++;
      $display("FAIL freq_window got=%h want ones=14 max=6 ef=1 er=0 fc=1 al=0", act_vec);
    end
    pat = 16'b0110_0110_0110_0110;
    for (int i = 15; i >= 0; i--) begin
      step(1'b1, pat[i], 1'b0);
      checks++;
      if (act_vec !== exp_vec()) begin
        failures++;
        $display("FAIL freq_pass_step%0d got=%h want=%h", i, act_vec, exp_vec());
      end
    end
    checks++;
    if (ones_count !== 5'd8 || fail_cnt !== 4'd0 || err_freq !== 1'b1) begin
      failures++;
      $display("FAIL freq_pass_window got=%h want ones=8 fc=0 ef=1", act_vec);
    end
  endtask

  task automatic test_rct_gaps();
    logic [7:0] tail;
    step(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b1, 1'b0);
      checks++;
      if (err_rct !== (i == 7) || alarm !== (i == 7)) begin
        failures++;
        $display("FAIL rct_one%0d err_rct=%b alarm=%b want %b", i, err_rct, alarm, i == 7);
      end
      for (int g = 0; g < 2; g++) begin
        step(1'b0, 1'($urandom_range(0, 1)), 1'b0);
        checks++;
        if (act_vec !== exp_vec()) begin
          failures++;
          $display("FAIL rct_gap%0d_%0d got=%h want=%h", i, g, act_vec, exp_vec());
        end
      end
    end
    tail = 8'b0101_0101;
    for (int i = 7; i >= 0; i--) begin
      step(1'b1, tail[i], 1'b0);
      checks++;
      if (act_vec !== exp_vec()) begin
        failures++;
        $display("FAIL rct_tail%0d got=%h want=%h", i, act_vec, exp_vec());
      end
    end
    checks++;
    if (win_done !== 1'b1 || max_run !== 4'd8 || err_runs !== 1'b1 || ones_count !== 5'd12 ||
        err_freq !== 1'b0) begin
      failures++;
      $display("FAIL rct_window got=%h want done=1 max=8 er=1 ones=12 ef=0", act_vec);
    end
  endtask

  task automatic test_back_to_back_fail();
    logic [15:0] pat;
    step(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 2 * WIN_LEN; i++) begin
      step(1'b1, 1'b0, 1'b0);
      checks++;
      if (act_vec !== exp_vec()) begin
        failures++;
        $display("FAIL zeros_step%0d got=%h want=%h", i, act_vec, exp_vec());
      end
      if (i == WIN_LEN - 1) begin
        checks++;
        if (win_done !== 1'b1 || fail_cnt !== 4'd1 || max_run !== 4'd8 || ones_count !== 5'd0) begin
          failures++;
          $display("FAIL zeros_win1 got=%h want done=1 fc=1 max=8 ones=0", act_vec);
        end
      end
    end
    checks++;
    if (win_done !== 1'b1 || fail_cnt !== 4'd2 || alarm !== 1'b1) begin
      failures++;
      $display("FAIL zeros_win2 got=%h want done=1 fc=2 alarm=1", act_vec);
    end
    step(1'b1, 1'b1, 1'b1);
    checks++;
    if (act_vec !== 18'd0) begin
      failures++;
      $display("FAIL clear_with_valid got=%h want=%h", act_vec, 18'd0);
    end
    pat = 16'b1000_1000_1000_1000;
    for (int i = 15; i >= 0; i--) begin
      step(1'b1, pat[i], 1'b0);
      checks++;
      if (act_vec !== exp_vec()) begin
        failures++;
        $display("FAIL post_clear_step%0d got=%h want=%h", i, act_vec, exp_vec());
      end
    end
    checks++;
    if (win_done !== 1'b1 || ones_count !== 5'd4 || err_freq !== 1'b0 || fail_cnt !== 4'd0) begin
      failures++;
      $display("FAIL post_clear_window got=%h want done=1 ones=4 ef=0 fc=0", act_vec);
    end
  endtask

  task automatic test_random();
    int p;
    bit b;
    for (int w = 0; w < 10; w++) begin
      p = $urandom_range(5, 95);
      for (int i = 0; i < WIN_LEN; i++) begin
        repeat ($urandom_range(0, 2)) begin
          step(1'b0, 1'($urandom_range(0, 1)), 1'b0);
          checks++;
          if (act_vec !== exp_vec()) begin
            failures++;
            $display("FAIL rand_gap w%0d b%0d got=%h want=%h", w, i, act_vec, exp_vec());
          end
        end
        b = ($urandom_range(0, 99) < p);
        step(1'b1, b, $urandom_range(0, 79) == 0);
        checks++;
        if (act_vec !== exp_vec()) begin
          failures++;
          $display("FAIL rand_bit w%0d b%0d got=%h want=%h", w, i, act_vec, exp_vec());
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    model_reset();
    test_reset();
    test_alternating();
    test_async_reset();
    test_freq_fail();
    test_rct_gaps();
    test_back_to_back_fail();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
